// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard / sequencing controller.
//   REG_IDX_W         : width of a register-file index (x0..x31)
//   FWD_REG/MEM/WB    : EX operand forward-select encodings
//   mem_state_e       : data-memory handshake FSM states
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundles every pipeline-side signal of the hazard controller.
//   slave  modport : used by hazard_ctrl (i_* in, o_* out)
//   master modport : used by the pipeline / bench (drives i_*, observes o_*)
// Parameter CNT_W sets the width of the two performance counters.
// -----------------------------------------------------------------------------
interface hazard_ctrl_if import hazard_pkg::*; #(
    parameter int CNT_W = 32
) ();

    logic [REG_IDX_W-1:0] i_id_rs1;
    logic [REG_IDX_W-1:0] i_id_rs2;
    logic                 i_id_use_rs1;
    logic                 i_id_use_rs2;
    logic [REG_IDX_W-1:0] i_ex_rs1;
    logic [REG_IDX_W-1:0] i_ex_rs2;
    logic [REG_IDX_W-1:0] i_ex_rd;
    logic                 i_ex_mem_read;
    logic                 i_ex_pc_src;
    logic [REG_IDX_W-1:0] i_mem_rd;
    logic                 i_mem_reg_write;
    logic                 i_mem_access;
    logic [REG_IDX_W-1:0] i_wb_rd;
    logic                 i_wb_reg_write;
    logic                 i_dmem_valid;

    logic                 o_dmem_req;
    logic [1:0]           o_fwd_a;
    logic [1:0]           o_fwd_b;
    logic                 o_stall_if;
    logic                 o_stall_id;
    logic                 o_flush_id;
    logic                 o_bubble_ex;
    logic                 o_stall_all;
    logic                 o_mem_err;
    logic [CNT_W-1:0]     o_stall_cycles;
    logic [CNT_W-1:0]     o_flush_count;

    modport slave (
        input  i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
        input  i_ex_rs1, i_ex_rs2, i_ex_rd, i_ex_mem_read, i_ex_pc_src,
        input  i_mem_rd, i_mem_reg_write, i_mem_access,
        input  i_wb_rd, i_wb_reg_write, i_dmem_valid,
        output o_dmem_req, o_fwd_a, o_fwd_b, o_stall_if, o_stall_id,
        output o_flush_id, o_bubble_ex, o_stall_all, o_mem_err,
        output o_stall_cycles, o_flush_count
    );

    modport master (
        output i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
        output i_ex_rs1, i_ex_rs2, i_ex_rd, i_ex_mem_read, i_ex_pc_src,
        output i_mem_rd, i_mem_reg_write, i_mem_access,
        output i_wb_rd, i_wb_reg_write, i_dmem_valid,
        input  o_dmem_req, o_fwd_a, o_fwd_b, o_stall_if, o_stall_id,
        input  o_flush_id, o_bubble_ex, o_stall_all, o_mem_err,
        input  o_stall_cycles, o_flush_count
    );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// -----------------------------------------------------------------------------
// fwd_sel
// Combinational forward select for one EX operand.
//   ex_rs         : EX-stage source register of this operand
//   mem_rd/_wr    : MEM-stage destination and its write enable
//   wb_rd/_wr     : WB-stage destination and its write enable
//   sel           : FWD_MEM / FWD_WB / FWD_REG
// -----------------------------------------------------------------------------
module fwd_sel import hazard_pkg::*; (
    input  logic [REG_IDX_W-1:0] ex_rs,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic                 mem_wr,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 wb_wr,
    output logic [1:0]           sel
);

    // The MEM stage holds the younger result, so it is checked first.
    // x0 is never forwarded because it is hard-wired to zero.
    always_comb begin
        sel = FWD_REG;
        if (mem_wr && (mem_rd != '0) && (mem_rd == ex_rs)) begin
            sel = FWD_MEM;
        end else if (wb_wr && (wb_rd != '0) && (wb_rd == ex_rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencing controller for the 5-stage RV32I core.
//   i_clk, i_rst : core clock, synchronous active-high reset
//   bus (slave)  : per-stage register indices and control bits in;
//                  forward selects, stall/flush/bubble controls, data-memory
//                  request strobe, timeout flag and perf counters out.
// Parameters:
//   CNT_W   : perf counter width (counters wrap)
//   TIMEOUT : max not-ready cycles in WAIT before o_mem_err; 0 = no watchdog
// -----------------------------------------------------------------------------
module hazard_ctrl import hazard_pkg::*; #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    hazard_ctrl_if.slave  bus
);

    localparam bit          WDOG_EN   = (TIMEOUT > 0);
    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT);

    mem_state_e        state_q, state_d;
    logic [31:0]       tmo_cnt_q, tmo_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic dmem_req;
    logic stall_all;
    logic load_use;
    logic stall_if;
    logic flush_id;
    logic bubble_ex;

    // One selector per EX operand; both share the MEM/WB writeback info.
    fwd_sel u_fwd_a (
        .ex_rs  (bus.i_ex_rs1),
        .mem_rd (bus.i_mem_rd),
        .mem_wr (bus.i_mem_reg_write),
        .wb_rd  (bus.i_wb_rd),
        .wb_wr  (bus.i_wb_reg_write),
        .sel    (bus.o_fwd_a)
    );

    fwd_sel u_fwd_b (
        .ex_rs  (bus.i_ex_rs2),
        .mem_rd (bus.i_mem_rd),
        .mem_wr (bus.i_mem_reg_write),
        .wb_rd  (bus.i_wb_rd),
        .wb_wr  (bus.i_wb_reg_write),
        .sel    (bus.o_fwd_b)
    );

    // Data-memory handshake. The request cycle itself freezes the pipe, then
    // WAIT keeps it frozen until the memory answers. The answering cycle is
    // unfrozen so the MEM instruction advances with its data. The watchdog
    // gives up after TIMEOUT not-ready WAIT cycles and raises a sticky error.
    // While reset is asserted the strobes are suppressed so nothing is issued.
    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        mem_err_d = mem_err_q;
        dmem_req  = 1'b0;
        stall_all = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_mem_access) begin
                    dmem_req  = 1'b1;
                    stall_all = 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (bus.i_dmem_valid) begin
                    state_d = IDLE;
                end else begin
                    stall_all = 1'b1;
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                    if (WDOG_EN && (tmo_cnt_d == TMO_LIMIT)) begin
                        mem_err_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (i_rst) begin
            dmem_req  = 1'b0;
            stall_all = 1'b0;
        end
    end

    // Load-use and branch control. A taken branch squashes the dependent
    // instruction anyway, so it overrides the load-use stall. During a
    // memory freeze nothing moves, so these controls are held off and the
    // hazards are simply seen again once the pipe is released.
    always_comb begin
        load_use  = bus.i_ex_mem_read && (bus.i_ex_rd != '0) &&
                    ((bus.i_id_use_rs1 && (bus.i_id_rs1 == bus.i_ex_rd)) ||
                     (bus.i_id_use_rs2 && (bus.i_id_rs2 == bus.i_ex_rd)));
        stall_if  = !stall_all && load_use && !bus.i_ex_pc_src;
        flush_id  = !stall_all && bus.i_ex_pc_src;
        bubble_ex = !stall_all && (load_use || bus.i_ex_pc_src);
    end

    // Performance counters, free-running and wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, (stall_all || stall_if)};
        flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, flush_id};
    end

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            tmo_cnt_q   <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.o_dmem_req     = dmem_req;
    assign bus.o_stall_all    = stall_all;
    assign bus.o_stall_if     = stall_if;
    assign bus.o_stall_id     = stall_if;
    assign bus.o_flush_id     = flush_id;
    assign bus.o_bubble_ex    = bubble_ex;
    assign bus.o_mem_err      = mem_err_q;
    assign bus.o_stall_cycles = stall_cnt_q;
    assign bus.o_flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations followed by randomized traffic compared every cycle against a
// behavioural model of the controller.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int CNT_W   = 5;
    localparam int TIMEOUT = 8;
    localparam int unsigned CNT_MASK = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       rst;
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_use_rs1;
        logic       id_use_rs2;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] ex_rd;
        logic       ex_mem_read;
        logic       ex_pc_src;
        logic [4:0] mem_rd;
        logic       mem_reg_write;
        logic       mem_access;
        logic [4:0] wb_rd;
        logic       wb_reg_write;
        logic       dmem_valid;
    } stim_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

    hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (hif)
    );

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Behavioural model state: is a memory access outstanding, how many
    // not-ready cycles it has waited, the sticky error, and the event tallies.
    bit          m_busy    = 1'b0;
    int          m_waited  = 0;
    bit          m_err     = 1'b0;
    int unsigned m_stalls  = 0;
    int unsigned m_flushes = 0;

    // Compare one value and report it on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Drive one cycle worth of inputs just after the rising edge.
    task automatic applyStimulus(input stim_t s);
        @(posedge clk);
        #1;
        rst                 = s.rst;
        hif.i_id_rs1        = s.id_rs1;
        hif.i_id_rs2        = s.id_rs2;
        hif.i_id_use_rs1    = s.id_use_rs1;
        hif.i_id_use_rs2    = s.id_use_rs2;
        hif.i_ex_rs1        = s.ex_rs1;
        hif.i_ex_rs2        = s.ex_rs2;
        hif.i_ex_rd         = s.ex_rd;
        hif.i_ex_mem_read   = s.ex_mem_read;
        hif.i_ex_pc_src     = s.ex_pc_src;
        hif.i_mem_rd        = s.mem_rd;
        hif.i_mem_reg_write = s.mem_reg_write;
        hif.i_mem_access    = s.mem_access;
        hif.i_wb_rd         = s.wb_rd;
        hif.i_wb_reg_write  = s.wb_reg_write;
        hif.i_dmem_valid    = s.dmem_valid;
    endtask

    // Which stage's result an operand should take: the nearest producer wins.
    function automatic logic [1:0] modelFwd(input logic [4:0] rs);
        if (hif.i_mem_reg_write && hif.i_mem_rd != 0 && hif.i_mem_rd == rs) return 2'd1;
        if (hif.i_wb_reg_write && hif.i_wb_rd != 0 && hif.i_wb_rd == rs) return 2'd2;
        return 2'd0;
    endfunction

    // Per-cycle comparison against the model, then advance the model to
    // what the next rising edge will do.
    always @(negedge clk) begin
        bit lu, frozen, req, e_stall_if, e_flush, e_bubble;
        if (check_en) begin
            lu = hif.i_ex_mem_read && hif.i_ex_rd != 0 &&
                 ((hif.i_id_use_rs1 && hif.i_id_rs1 == hif.i_ex_rd) ||
                  (hif.i_id_use_rs2 && hif.i_id_rs2 == hif.i_ex_rd));
            req        = !rst && !m_busy && hif.i_mem_access;
            frozen     = !rst && (m_busy ? !hif.i_dmem_valid : hif.i_mem_access);
            e_stall_if = !frozen && lu && !hif.i_ex_pc_src;
            e_flush    = !frozen && hif.i_ex_pc_src;
            e_bubble   = !frozen && (lu || hif.i_ex_pc_src);

            checkOutput("fwd_a",       32'(hif.o_fwd_a),        32'(modelFwd(hif.i_ex_rs1)));
            checkOutput("fwd_b",       32'(hif.o_fwd_b),        32'(modelFwd(hif.i_ex_rs2)));
            checkOutput("dmem_req",    32'(hif.o_dmem_req),     32'(req));
            checkOutput("stall_all",   32'(hif.o_stall_all),    32'(frozen));
            checkOutput("stall_if",    32'(hif.o_stall_if),     32'(e_stall_if));
            checkOutput("stall_id",    32'(hif.o_stall_id),     32'(e_stall_if));
            checkOutput("flush_id",    32'(hif.o_flush_id),     32'(e_flush));
            checkOutput("bubble_ex",   32'(hif.o_bubble_ex),    32'(e_bubble));
            checkOutput("mem_err",     32'(hif.o_mem_err),      32'(m_err));
            checkOutput("stall_cycles",32'(hif.o_stall_cycles), m_stalls);
            checkOutput("flush_count", 32'(hif.o_flush_count),  m_flushes);

            if (rst) begin
                m_busy = 0; m_waited = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
            end else begin
                m_stalls  = (m_stalls + ((frozen || e_stall_if) ? 1 : 0)) & CNT_MASK;
                m_flushes = (m_flushes + (e_flush ? 1 : 0)) & CNT_MASK;
                if (!m_busy) begin
                    if (hif.i_mem_access) begin
                        m_busy = 1; m_waited = 0;
                    end
                end else if (hif.i_dmem_valid) begin
                    m_busy = 0;
                end else begin
                    m_waited++;
                    if (TIMEOUT > 0 && m_waited >= TIMEOUT) begin
                        m_err = 1; m_busy = 0;
                    end
                end
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1;
        s = idleStim();
        s.rst = 1'b1;
        applyStimulus(s);
        check_en = 1'b1;
        #1;
        checkOutput("rst_dmem_req", 32'(hif.o_dmem_req), 32'd0);
        checkOutput("rst_mem_err", 32'(hif.o_mem_err), 32'd0);
        checkOutput("rst_stall_cycles", 32'(hif.o_stall_cycles), 32'd0);
        checkOutput("rst_flush_count", 32'(hif.o_flush_count), 32'd0);

        // Forwarding priority and x0 handling.
        s = idleStim();
        s.mem_rd = 5; s.mem_reg_write = 1; s.wb_rd = 5; s.wb_reg_write = 1; s.ex_rs1 = 5;
        applyStimulus(s); #1;
        checkOutput("lit_fwd_a_mem", 32'(hif.o_fwd_a), 32'd1);
        s.mem_rd = 0;
        applyStimulus(s); #1;
        checkOutput("lit_fwd_a_wb", 32'(hif.o_fwd_a), 32'd2);
        s.ex_rs2 = 0; s.wb_rd = 0;
        applyStimulus(s); #1;
        checkOutput("lit_fwd_b_reg", 32'(hif.o_fwd_b), 32'd0);
        checkOutput("lit_fwd_a_reg", 32'(hif.o_fwd_a), 32'd0);

        // Load-use stall for one cycle.
        s = idleStim();
        s.ex_mem_read = 1; s.ex_rd = 7; s.id_use_rs2 = 1; s.id_rs2 = 7;
        applyStimulus(s); #1;
        checkOutput("lit_lu_stall_if", 32'(hif.o_stall_if), 32'd1);
        checkOutput("lit_lu_stall_id", 32'(hif.o_stall_id), 32'd1);
        checkOutput("lit_lu_bubble", 32'(hif.o_bubble_ex), 32'd1);
        checkOutput("lit_lu_flush", 32'(hif.o_flush_id), 32'd0);
        applyStimulus(idleStim()); #1;
        checkOutput("lit_lu_release", 32'(hif.o_stall_if), 32'd0);
        checkOutput("lit_lu_stall_cnt", 32'(hif.o_stall_cycles), 32'd1);

        // Branch beats load-use.
        s.ex_pc_src = 1;
        applyStimulus(s); #1;
        checkOutput("lit_br_flush", 32'(hif.o_flush_id), 32'd1);
        checkOutput("lit_br_bubble", 32'(hif.o_bubble_ex), 32'd1);
        checkOutput("lit_br_stall_if", 32'(hif.o_stall_if), 32'd0);
        applyStimulus(idleStim()); #1;
        checkOutput("lit_br_flush_cnt", 32'(hif.o_flush_count), 32'd1);
        checkOutput("lit_br_stall_cnt", 32'(hif.o_stall_cycles), 32'd1);

        // Memory access answered after three not-ready WAIT cycles.
        s = idleStim();
        s.mem_access = 1;
        applyStimulus(s); #1;
        checkOutput("lit_mem_req", 32'(hif.o_dmem_req), 32'd1);
        checkOutput("lit_mem_stall0", 32'(hif.o_stall_all), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(s); #1;
            checkOutput("lit_mem_wait_req", 32'(hif.o_dmem_req), 32'd0);
            checkOutput("lit_mem_wait_stall", 32'(hif.o_stall_all), 32'd1);
        end
        s.dmem_valid = 1;
        applyStimulus(s); #1;
        checkOutput("lit_mem_valid_stall", 32'(hif.o_stall_all), 32'd0);
        applyStimulus(idleStim()); #1;
        checkOutput("lit_mem_stall_cnt", 32'(hif.o_stall_cycles), 32'd5);
        checkOutput("lit_mem_idle_req", 32'(hif.o_dmem_req), 32'd0);

        // Watchdog: memory never answers.
        s = idleStim();
        s.mem_access = 1;
        applyStimulus(s); #1;
        checkOutput("lit_wd_req", 32'(hif.o_dmem_req), 32'd1);
        for (int i = 0; i < TIMEOUT; i++) begin
            applyStimulus(idleStim()); #1;
            checkOutput("lit_wd_wait_stall", 32'(hif.o_stall_all), 32'd1);
            checkOutput("lit_wd_no_err_yet", 32'(hif.o_mem_err), 32'd0);
        end
        applyStimulus(idleStim()); #1;
        checkOutput("lit_wd_err", 32'(hif.o_mem_err), 32'd1);
        checkOutput("lit_wd_released", 32'(hif.o_stall_all), 32'd0);
        checkOutput("lit_wd_stall_cnt", 32'(hif.o_stall_cycles), 32'd14);
        repeat (3) applyStimulus(idleStim());
        #1;
        checkOutput("lit_wd_sticky", 32'(hif.o_mem_err), 32'd1);

        // Reset in the second WAIT cycle; the late valid must be ignored.
        s = idleStim();
        s.mem_access = 1;
        applyStimulus(s);
        applyStimulus(idleStim());
        s = idleStim();
        s.rst = 1;
        applyStimulus(s); #1;
        checkOutput("lit_rw_rst_req", 32'(hif.o_dmem_req), 32'd0);
        s = idleStim();
        s.dmem_valid = 1;
        applyStimulus(s); #1;
        checkOutput("lit_rw_stall", 32'(hif.o_stall_all), 32'd0);
        checkOutput("lit_rw_req", 32'(hif.o_dmem_req), 32'd0);
        checkOutput("lit_rw_err", 32'(hif.o_mem_err), 32'd0);
        checkOutput("lit_rw_stall_cnt", 32'(hif.o_stall_cycles), 32'd0);
        checkOutput("lit_rw_flush_cnt", 32'(hif.o_flush_count), 32'd0);

        // Randomized traffic with small register indices to provoke matches.
        for (int n = 0; n < 3000; n++) begin
            s.rst           = ($urandom_range(0, 99) == 0);
            s.id_rs1        = 5'($urandom_range(0, 3));
            s.id_rs2        = 5'($urandom_range(0, 3));
            s.id_use_rs1    = 1'($urandom_range(0, 1));
            s.id_use_rs2    = 1'($urandom_range(0, 1));
            s.ex_rs1        = 5'($urandom_range(0, 3));
            s.ex_rs2        = 5'($urandom_range(0, 3));
            s.ex_rd         = 5'($urandom_range(0, 3));
            s.ex_mem_read   = 1'($urandom_range(0, 1));
            s.ex_pc_src     = ($urandom_range(0, 4) == 0);
            s.mem_rd        = 5'($urandom_range(0, 3));
            s.mem_reg_write = 1'($urandom_range(0, 1));
            s.mem_access    = ($urandom_range(0, 3) == 0);
            s.wb_rd         = 5'($urandom_range(0, 3));
            s.wb_reg_write  = 1'($urandom_range(0, 1));
            s.dmem_valid    = ($urandom_range(0, 9) < 3);
            applyStimulus(s);
        end

        @(negedge clk);
        #1;
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
